rtc_time_reader: RTL

Transaction sequencer that sits directly upstream of the I2C byte engine (i2c) and drives its command interface.
- On request, or periodically, performs an RTC register read: START, address+W, register pointer, repeated START, address+R, NUM_BYTES reads, STOP.
- Presents the captured bytes as one packed, atomically updated time word to the display/UART logic.
- Detects slave NACK and engine stall, and always releases the bus with STOP.

---
 rtl/rtc_time_reader.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_time_reader.sv
`default_nettype none
// ============================================================================
// Module : rtc_time_reader
// Drives an I2C byte engine through an RTC register read and publishes the bytes as one time word.
// Rev    : 1.0
// ============================================================================
module rtc_time_reader #(
    parameter logic [6:0] RTC_ADDR       = 7'h68,
    parameter logic [7:0] START_REG      = 8'h00,
    parameter int         NUM_BYTES      = 3,
    parameter int         POLL_CYCLES    = 100_000_000,
    parameter int         TIMEOUT_CYCLES = 200_000
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_req,
    output logic                   o_busy,
    output logic [8*NUM_BYTES-1:0] o_time,
    output logic                   o_time_valid,
    output logic                   o_err_nack,
    output logic                   o_err_timeout,
    output logic                   o_i2c_start,
    output logic                   o_i2c_stop,
    output logic                   o_i2c_wr,
    output logic                   o_i2c_rd,
    output logic                   o_i2c_rd_last,
    output logic [7:0]             o_i2c_wr_byte,
    input  logic                   i_i2c_tx_done,
    input  logic                   i_i2c_ack,
    input  logic                   i_i2c_dataval,
    input  logic [7:0]             i_i2c_rd_byte
);

    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int PW    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0]    c_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_START1   = 4'd1,
        S_WR_AW    = 4'd2,
        S_WR_PTR   = 4'd3,
        S_START2   = 4'd4,
        S_WR_AR    = 4'd5,
        S_RD       = 4'd6,
        S_STOP     = 4'd7,
        S_DONE     = 4'd8,
        S_ERR_STOP = 4'd9
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_issue;
    logic                     w_issue_nxt;
    logic                     w_nack;
    logic                     w_expire;
    logic                     w_cmd_state;
    logic                     w_wait;
    logic                     w_done;
    logic                     w_trigger;
    logic                     w_poll;
    logic [TW-1:0]            r_tmo;
    logic [IDX_W-1:0]         r_idx;
    logic [8*NUM_BYTES-1:0]   r_shadow;
    logic [8*NUM_BYTES-1:0]   r_time;
    logic                     r_time_valid;
    logic                     r_err_nack;
    logic                     r_err_timeout;

    generate
        if (POLL_CYCLES > 0) begin : g_poll
            logic [PW-1:0] r_poll;
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_poll <= '0;
                end else if (r_poll == PW'(POLL_CYCLES - 1)) begin
                    r_poll <= '0;
                end else begin
                    r_poll <= r_poll + PW'(1);
                end
            end
            assign w_poll = (r_poll == PW'(POLL_CYCLES - 1));
        end else begin : g_no_poll
            assign w_poll = 1'b0;
        end
    endgenerate

    // Every state except IDLE and DONE owns exactly one engine command.
    assign w_trigger   = i_req | w_poll;
    assign w_cmd_state = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_wait      = w_cmd_state && !r_issue;
    assign w_done      = w_wait && i_i2c_tx_done;
    assign w_expire    = w_wait && !i_i2c_tx_done && (r_tmo == c_TMO_LAST);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_issue <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_issue <= w_issue_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_nxt = 1'b0;
        w_nack      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = S_START1;
                    w_issue_nxt = 1'b1;
                end
            end
            S_START1: begin
                if (w_done) begin
                    w_state_nxt = S_WR_AW;
                    w_issue_nxt = 1'b1;
                end
            end
            S_WR_AW, S_WR_PTR, S_WR_AR: begin
                if (w_done) begin
                    w_issue_nxt = 1'b1;
                    if (!i_i2c_ack) begin
                        w_nack      = 1'b1;
                        w_state_nxt = S_ERR_STOP;
                    end else if (r_state == S_WR_AW) begin
                        w_state_nxt = S_WR_PTR;
                    end else if (r_state == S_WR_PTR) begin
                        w_state_nxt = S_START2;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_START2: begin
                if (w_done) begin
                    w_state_nxt = S_WR_AR;
                    w_issue_nxt = 1'b1;
                end
            end
            S_RD: begin
                if (w_done) begin
                    w_issue_nxt = 1'b1;
                    w_state_nxt = (r_idx == c_IDX_LAST) ? S_STOP : S_RD;
                end
            end
            S_STOP: begin
                if (w_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_ERR_STOP: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A stuck STOP is abandoned rather than retried with another STOP.
        if (w_expire) begin
            if ((r_state == S_STOP) || (r_state == S_ERR_STOP)) begin
                w_state_nxt = S_IDLE;
                w_issue_nxt = 1'b0;
            end else begin
                w_state_nxt = S_ERR_STOP;
                w_issue_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_tmo         <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_time        <= '0;
            r_time_valid  <= 1'b0;
            r_err_nack    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_nack    <= w_nack;
            r_err_timeout <= w_expire;
            r_time_valid  <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_time <= r_shadow;
            end
            if (w_issue_nxt) begin
                r_tmo <= '0;
            end else if (w_cmd_state) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (r_state == S_IDLE) begin
                r_idx <= '0;
            end else if ((r_state == S_RD) && w_done) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if ((r_state == S_RD) && i_i2c_dataval) begin
                r_shadow[{r_idx, 3'b000} +: 8] <= i_i2c_rd_byte;
            end
        end
    end

    always_comb begin
        o_i2c_wr_byte = 8'h00;
        case (r_state)
            S_WR_AW:  o_i2c_wr_byte = {RTC_ADDR, 1'b0};
            S_WR_PTR: o_i2c_wr_byte = START_REG;
            S_WR_AR:  o_i2c_wr_byte = {RTC_ADDR, 1'b1};
            default:  o_i2c_wr_byte = 8'h00;
        endcase
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_time        = r_time;
    assign o_time_valid  = r_time_valid;
    assign o_err_nack    = r_err_nack;
    assign o_err_timeout = r_err_timeout;
    assign o_i2c_start   = r_issue && ((r_state == S_START1) || (r_state == S_START2));
    assign o_i2c_stop    = r_issue && ((r_state == S_STOP) || (r_state == S_ERR_STOP));
    assign o_i2c_wr      = r_issue && ((r_state == S_WR_AW) || (r_state == S_WR_PTR) ||
                                       (r_state == S_WR_AR));
    assign o_i2c_rd      = r_issue && (r_state == S_RD);
    assign o_i2c_rd_last = r_issue && (r_state == S_RD) && (r_idx == c_IDX_LAST);

endmodule
`default_nettype wire
